// File: rtl/sparam_sweep_seq.sv
// N-port S-parameter sweep sequencer. It steps through frequency points and source ports,
// settles, averages receiver samples and streams one result per (freq, src, rcv) triple.
module sparam_sweep_seq #(
    parameter int unsigned NPORTS   = 4,
    parameter int unsigned NFREQ    = 16,
    parameter int unsigned SETTLE   = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned DW       = 12,
    localparam int unsigned FW      = (NFREQ > 1) ? $clog2(NFREQ) : 1,
    localparam int unsigned PW      = $clog2(NPORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [FW-1:0]        freq_idx_o,
    output logic [NPORTS-1:0]    src_sel_o,
    input  logic                 smp_valid_i,
    input  logic [NPORTS*DW-1:0] smp_data_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [DW-1:0]        res_data_o,
    output logic [PW-1:0]        res_src_o,
    output logic [PW-1:0]        res_rcv_o,
    output logic [FW-1:0]        res_freq_o
);

    localparam int unsigned AW   = DW + AVG_LOG2;
    localparam int unsigned NSMP = 1 << AVG_LOG2;
    localparam int unsigned CW   = AVG_LOG2 + 1;
    localparam int unsigned SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACQ,
        ST_EMIT
    } state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [CW-1:0]       smp_cnt_q, smp_cnt_d;
    logic [FW-1:0]       freq_q, freq_d;
    logic [PW-1:0]       src_q, src_d;
    logic [PW-1:0]       rcv_q, rcv_d;
    logic [AW-1:0]       acc_q [NPORTS];
    logic [AW-1:0]       acc_d [NPORTS];
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NPORTS-1:0]   src_sel_q, src_sel_d;
    logic                res_valid_q, res_valid_d;
    logic [DW-1:0]       res_data_q, res_data_d;
    logic [PW-1:0]       res_src_q, res_src_d;
    logic [PW-1:0]       res_rcv_q, res_rcv_d;
    logic [FW-1:0]       res_freq_q, res_freq_d;

    // Sweep sequencing: next-state and next-output computation
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        smp_cnt_d  = smp_cnt_q;
        freq_d     = freq_q;
        src_d      = src_q;
        rcv_d      = rcv_q;
        acc_d      = acc_q;
        done_d     = 1'b0;
        res_data_d = res_data_q;
        res_src_d  = res_src_q;
        res_rcv_d  = res_rcv_q;
        res_freq_d = res_freq_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_SETTLE;
                    freq_d   = '0;
                    src_d    = '0;
                    rcv_d    = '0;
                    settle_d = SW'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d   = ST_ACQ;
                    smp_cnt_d = '0;
                    for (int k = 0; k < int'(NPORTS); k++) begin
                        acc_d[k] = '0;
                    end
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_ACQ: begin
                if (smp_valid_i) begin
                    for (int k = 0; k < int'(NPORTS); k++) begin
                        acc_d[k] = acc_q[k] + AW'(smp_data_i[k*DW +: DW]);
                    end
                    if (smp_cnt_q == CW'(NSMP - 1)) begin
                        state_d = ST_EMIT;
                        rcv_d   = '0;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (res_ready_i) begin
                    if (rcv_q != PW'(NPORTS - 1)) begin
                        rcv_d = rcv_q + 1'b1;
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = SW'(SETTLE - 1);
                        if (src_q != PW'(NPORTS - 1)) begin
                            src_d = src_q + 1'b1;
                        end else if (freq_q != FW'(NFREQ - 1)) begin
                            freq_d = freq_q + 1'b1;
                            src_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops the sweep and any pending result, without a done pulse
        if (abort_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end

        busy_d      = (state_d != ST_IDLE);
        src_sel_d   = busy_d ? (NPORTS'(1) << src_d) : '0;
        res_valid_d = (state_d == ST_EMIT);

        // Result fields are loaded from the next-state view so the first result
        // includes the final sample and back-to-back transfers need no bubble
        if (state_d == ST_EMIT) begin
            res_data_d = DW'(acc_d[rcv_d] >> AVG_LOG2);
            res_src_d  = src_d;
            res_rcv_d  = rcv_d;
            res_freq_d = freq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            smp_cnt_q   <= '0;
            freq_q      <= '0;
            src_q       <= '0;
            rcv_q       <= '0;
            for (int k = 0; k < int'(NPORTS); k++) begin
                acc_q[k] <= '0;
            end
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            src_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_src_q   <= '0;
            res_rcv_q   <= '0;
            res_freq_q  <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            smp_cnt_q   <= smp_cnt_d;
            freq_q      <= freq_d;
            src_q       <= src_d;
            rcv_q       <= rcv_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            src_sel_q   <= src_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_src_q   <= res_src_d;
            res_rcv_q   <= res_rcv_d;
            res_freq_q  <= res_freq_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign freq_idx_o  = freq_q;
    assign src_sel_o   = src_sel_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_src_o   = res_src_q;
    assign res_rcv_o   = res_rcv_q;
    assign res_freq_o  = res_freq_q;

endmodule

// File: tb/tb_sparam_sweep_seq.sv
// Randomized bench for sparam_sweep_seq: a sample-list reference model plus directed
// checks for ordering, latency, truncation, backpressure, gaps, abort and reset.
module tb_sparam_sweep_seq;

    localparam int NPORTS   = 4;
    localparam int NFREQ    = 2;
    localparam int SETTLE   = 3;
    localparam int AVG_LOG2 = 2;
    localparam int DW       = 12;
    localparam int NSMP     = 1 << AVG_LOG2;
    localparam int FW       = (NFREQ > 1) ? $clog2(NFREQ) : 1;
    localparam int PW       = $clog2(NPORTS);
    localparam int NRES     = NFREQ * NPORTS * NPORTS;

    logic                 clk;
    logic                 rst;
    logic                 start_i;
    logic                 abort_i;
    logic                 busy_o;
    logic                 done_o;
    logic [FW-1:0]        freq_idx_o;
    logic [NPORTS-1:0]    src_sel_o;
    logic                 smp_valid_i;
    logic [NPORTS*DW-1:0] smp_data_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [DW-1:0]        res_data_o;
    logic [PW-1:0]        res_src_o;
    logic [PW-1:0]        res_rcv_o;
    logic [FW-1:0]        res_freq_o;

    sparam_sweep_seq #(
        .NPORTS(NPORTS), .NFREQ(NFREQ), .SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .freq_idx_o(freq_idx_o), .src_sel_o(src_sel_o),
        .smp_valid_i(smp_valid_i), .smp_data_i(smp_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_src_o(res_src_o), .res_rcv_o(res_rcv_o), .res_freq_o(res_freq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int f;
        int s;
        int r;
        int d;
    } res_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc_n = 0;
    int   done_cnt = 0;
    int   dmode = 0;
    int   vmode = 0;
    int   rmode = 0;
    bit   rnd_start = 1'b0;
    res_t got [$];

    // Reference model: phase 0 idle, 1 settling, 2 collecting samples, 3 presenting results
    int   m_ph = 0;
    int   m_wait = 0;
    int   m_f = 0;
    int   m_s = 0;
    int   m_r = 0;
    int   m_n = 0;
    int   m_sum [NPORTS];
    bit   m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got_v, exp_v, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic st, input logic ab, input logic sv,
                              input logic [NPORTS*DW-1:0] d, input logic rr);
        m_done = 1'b0;
        if (r) begin
            m_ph = 0; m_f = 0; m_s = 0; m_r = 0; m_n = 0;
        end else if (ab) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (st) begin
                    m_ph = 1; m_f = 0; m_s = 0; m_wait = SETTLE;
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_ph = 2; m_n = 0;
                        for (int k = 0; k < NPORTS; k++) m_sum[k] = 0;
                    end
                end
                2: if (sv) begin
                    for (int k = 0; k < NPORTS; k++) m_sum[k] += int'(d[k*DW +: DW]);
                    m_n++;
                    if (m_n == NSMP) begin
                        m_ph = 3; m_r = 0;
                    end
                end
                default: if (rr) begin
                    if (m_r < NPORTS - 1) begin
                        m_r++;
                    end else if (m_s < NPORTS - 1) begin
                        m_s++; m_ph = 1; m_wait = SETTLE;
                    end else if (m_f < NFREQ - 1) begin
                        m_f++; m_s = 0; m_ph = 1; m_wait = SETTLE;
                    end else begin
                        m_ph = 0; m_done = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("busy", 32'(busy_o), 32'(m_ph != 0));
        chk("done", 32'(done_o), 32'(m_done));
        chk("src_sel", 32'(src_sel_o), (m_ph != 0) ? (32'd1 << m_s) : 32'd0);
        chk("freq_idx", 32'(freq_idx_o), 32'(m_f));
        chk("res_valid", 32'(res_valid_o), 32'(m_ph == 3));
        if (m_ph == 3) begin
            chk("res_data", 32'(res_data_o), 32'(m_sum[m_r] / NSMP));
            chk("res_src", 32'(res_src_o), 32'(m_s));
            chk("res_rcv", 32'(res_rcv_o), 32'(m_r));
            chk("res_freq", 32'(res_freq_o), 32'(m_f));
        end
    endtask

    // One clock: drive inputs, record any transfer, advance, then compare against the model
    task automatic cycle(input logic r, input logic st, input logic ab);
        logic [NPORTS*DW-1:0] d;
        logic                 sv;
        logic                 rr;
        logic                 st_eff;
        res_t                 t;
        cyc_n++;
        case (vmode)
            0:       sv = 1'b1;
            1:       sv = ((cyc_n % 2) == 0);
            default: sv = 1'($urandom_range(0, 1));
        endcase
        for (int k = 0; k < NPORTS; k++) begin
            logic [DW-1:0] v;
            case (dmode)
                0:       v = DW'(100 * (k + 1));
                1:       v = DW'($urandom);
                default: begin
                    if (k == 0)      v = (m_n == 0) ? DW'(1) : DW'(2);
                    else if (k == 1) v = DW'(4095);
                    else             v = DW'($urandom);
                end
            endcase
            d[k*DW +: DW] = v;
        end
        case (rmode)
            0:       rr = 1'b1;
            1:       rr = 1'($urandom_range(0, 1));
            default: rr = ((cyc_n % 12) >= 5);
        endcase
        st_eff = st | (rnd_start && (m_ph != 0) && ($urandom_range(0, 3) == 0));
        rst         = r;
        start_i     = st_eff;
        abort_i     = ab;
        smp_valid_i = sv;
        smp_data_i  = d;
        res_ready_i = rr;
        if (res_valid_o && rr && !r && !ab) begin
            t.f = int'(res_freq_o); t.s = int'(res_src_o);
            t.r = int'(res_rcv_o);  t.d = int'(res_data_o);
            got.push_back(t);
        end
        @(posedge clk);
        #1;
        model_step(r, st_eff, ab, sv, d, rr);
        if (done_o) done_cnt++;
        check_outputs();
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while (m_ph != 0 && n < 4000) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("sweep_end_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic check_order(input string tag);
        int i;
        chk({tag, "_count"}, 32'(got.size()), 32'(NRES));
        i = 0;
        for (int f = 0; f < NFREQ; f++)
            for (int s = 0; s < NPORTS; s++)
                for (int r = 0; r < NPORTS; r++) begin
                    if (i < got.size()) begin
                        chk({tag, "_ord_f"}, 32'(got[i].f), 32'(f));
                        chk({tag, "_ord_s"}, 32'(got[i].s), 32'(s));
                        chk({tag, "_ord_r"}, 32'(got[i].r), 32'(r));
                    end
                    i++;
                end
    endtask

    task automatic reset_values_chk(input string tag);
        chk({tag, "_busy"},      32'(busy_o), 32'd0);
        chk({tag, "_done"},      32'(done_o), 32'd0);
        chk({tag, "_freq_idx"},  32'(freq_idx_o), 32'd0);
        chk({tag, "_src_sel"},   32'(src_sel_o), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
        chk({tag, "_res_data"},  32'(res_data_o), 32'd0);
        chk({tag, "_res_src"},   32'(res_src_o), 32'd0);
        chk({tag, "_res_rcv"},   32'(res_rcv_o), 32'd0);
        chk({tag, "_res_freq"},  32'(res_freq_o), 32'd0);
    endtask

    initial begin
        int  lat;
        int  n;
        bit  any_valid;
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        smp_valid_i = 1'b0; smp_data_i = '0; res_ready_i = 1'b0;
        for (int k = 0; k < NPORTS; k++) m_sum[k] = 0;

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        reset_values_chk("reset");

        // Full sweep with constant channel levels and ideal handshake
        dmode = 0; vmode = 0; rmode = 0; rnd_start = 1'b0;
        got.delete(); done_cnt = 0;
        cycle(1'b0, 1'b1, 1'b0);
        lat = 1;
        while (!res_valid_o && lat < 64) begin
            cycle(1'b0, 1'b0, 1'b0);
            lat++;
        end
        chk("t1_latency", 32'(lat), 32'(1 + SETTLE + NSMP));
        run_until_idle();
        check_order("t1");
        foreach (got[i]) chk("t1_level", 32'(got[i].d), 32'(100 * (got[i].r + 1)));
        chk("t1_done_pulses", 32'(done_cnt), 32'd1);

        // Truncating average and full-scale samples; start lands in the done cycle
        dmode = 2; vmode = 0; rmode = 0;
        got.delete(); done_cnt = 0;
        cycle(1'b0, 1'b1, 1'b0);
        run_until_idle();
        check_order("t2");
        foreach (got[i]) begin
            if (got[i].r == 0) chk("t2_trunc", 32'(got[i].d), 32'd1);
            if (got[i].r == 1) chk("t2_fullscale", 32'(got[i].d), 32'd4095);
        end

        // Backpressure bursts with random sample gaps and starts while busy
        dmode = 1; vmode = 2; rmode = 2; rnd_start = 1'b1;
        got.delete(); done_cnt = 0;
        cycle(1'b0, 1'b1, 1'b0);
        run_until_idle();
        check_order("t3");
        chk("t3_done_pulses", 32'(done_cnt), 32'd1);

        // Alternating sample strobe, random ready
        dmode = 1; vmode = 1; rmode = 1; rnd_start = 1'b0;
        got.delete();
        cycle(1'b0, 1'b1, 1'b0);
        run_until_idle();
        check_order("t4");

        // Abort while acquiring freq 1 / src 2, then restart from the beginning
        dmode = 1; vmode = 2; rmode = 1;
        cycle(1'b0, 1'b1, 1'b0);
        n = 0;
        while (!(m_ph == 2 && m_f == 1 && m_s == 2) && n < 4000) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("t5_reached_acq", 32'(src_sel_o), 32'd4);
        done_cnt = 0;
        cycle(1'b0, 1'b0, 1'b1);
        chk("t5_abort_busy", 32'(busy_o), 32'd0);
        chk("t5_abort_src_sel", 32'(src_sel_o), 32'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (res_valid_o) any_valid = 1'b1;
        end
        chk("t5_no_valid", 32'(any_valid), 32'd0);
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        got.delete();
        cycle(1'b0, 1'b1, 1'b0);
        chk("t5_restart_freq", 32'(freq_idx_o), 32'd0);
        chk("t5_restart_src", 32'(src_sel_o), 32'd1);
        run_until_idle();
        check_order("t5");

        // Reset while a result of freq 1 is pending, then a clean sweep
        dmode = 1; vmode = 2; rmode = 1; rnd_start = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        n = 0;
        while (!(m_ph == 3 && m_f == 1) && n < 4000) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("t6_pending", 32'(res_valid_o), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        reset_values_chk("t6_reset");
        got.delete();
        cycle(1'b0, 1'b1, 1'b0);
        run_until_idle();
        check_order("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
